// File: rtl/psum_fifo.sv
// First-word-fall-through partial-sum FIFO between neighbouring PEs in a column.
// Optional sticky overflow/underflow detection is built when PSUM_FIFO_ERR_EN is defined.
module psum_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic                  push_ok;
  logic                  pop_ok;

  // Status decodes come only from the registered occupancy
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == CW'(0));
  assign almost_full = (DEPTH - 32'(count)) <= AF_MARGIN;

  // A pop frees the slot a push into a full FIFO needs
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop);

  assign dout = empty ? '0 : mem[rp];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= next_ptr(wp);
      if (pop_ok)  rp <= next_ptr(rp);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end

  // Storage has no reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (!reset && !clear && push_ok) mem[wp] <= din;
  end

`ifdef PSUM_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!clear) begin
      if (push && full && !pop) overflow  <= 1'b1;
      if (pop && empty)         underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_psum_fifo.sv
// Self-checking bench for psum_fifo: directed scenarios plus random traffic
// against a queue-based reference model, on a 16-deep and a 5-deep instance.
module tb_psum_fifo;

`ifdef PSUM_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, push, pop;
  logic [15:0] din, dout;
  logic        full, af, empty, ovf, unf;
  logic [4:0]  cnt;

  logic        clr5, push5, pop5;
  logic [15:0] din5, dout5;
  logic        full5, af5, empty5, ovf5, unf5;
  logic [2:0]  cnt5;

  int total = 0;
  int bad   = 0;

  logic [15:0] q16[$];
  logic [15:0] q5[$];
  logic        m_ovf, m_unf, m_ovf5, m_unf5;

  psum_fifo #(.DATA_WIDTH(16), .DEPTH(16), .AF_MARGIN(2)) u_dut (
    .clk(clk), .reset(rst), .clear(clr), .push(push), .din(din),
    .full(full), .almost_full(af), .pop(pop), .dout(dout), .empty(empty),
    .count(cnt), .overflow(ovf), .underflow(unf)
  );

  psum_fifo #(.DATA_WIDTH(16), .DEPTH(5), .AF_MARGIN(2)) u_dut5 (
    .clk(clk), .reset(rst), .clear(clr5), .push(push5), .din(din5),
    .full(full5), .almost_full(af5), .pop(pop5), .dout(dout5), .empty(empty5),
    .count(cnt5), .overflow(ovf5), .underflow(unf5)
  );

  // One clock: reference model follows the inputs seen at the edge, then settle
  task automatic cyc();
    bit e, f;
    @(posedge clk);
    if (rst) begin
      q16.delete(); q5.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_ovf5 = 1'b0; m_unf5 = 1'b0;
    end else begin
      if (clr) q16.delete();
      else begin
        e = (q16.size() == 0); f = (q16.size() == 16);
        if (ERR && push && f && !pop) m_ovf = 1'b1;
        if (ERR && pop && e) m_unf = 1'b1;
        if (pop && !e) void'(q16.pop_front());
        if (push && (!f || pop)) q16.push_back(din);
      end
      if (clr5) q5.delete();
      else begin
        e = (q5.size() == 0); f = (q5.size() == 5);
        if (ERR && push5 && f && !pop5) m_ovf5 = 1'b1;
        if (ERR && pop5 && e) m_unf5 = 1'b1;
        if (pop5 && !e) void'(q5.pop_front());
        if (push5 && (!f || pop5)) q5.push_back(din5);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    clr5 = 1'b0; push5 = 1'b0; pop5 = 1'b0; din5 = '0;
    cyc(); cyc();
    rst = 1'b0;
    total++; if (cnt !== 5'd0)   begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (af !== 1'b0)    begin bad++; $display("FAIL reset_af got=%b exp=0", af); end
    total++; if (dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    total++; if ({ovf, unf} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b%b exp=00", ovf, unf); end
    total++; if (empty5 !== 1'b1 || cnt5 !== 3'd0) begin bad++; $display("FAIL reset_d5 got=%b/%0d exp=1/0", empty5, cnt5); end
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 16'(16'h0011 * (i + 1));
      cyc();
      total++; if (cnt !== 5'(i + 1)) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", cnt, i + 1); end
      total++; if (dout !== 16'h0011) begin bad++; $display("FAIL basic_head got=%h exp=0011", dout); end
    end
    push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = 16'(16'h0011 * (i + 1));
      total++; if (dout !== exp) begin bad++; $display("FAIL basic_pop got=%h exp=%h", dout, exp); end
      pop = 1'b1; cyc(); pop = 1'b0;
    end
    total++; if (empty !== 1'b1 || dout !== 16'h0) begin bad++; $display("FAIL basic_drained got=%b/%h exp=1/0000", empty, dout); end
  endtask

  task automatic test_fill_overflow();
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 16'h0100 + 16'(i);
      cyc();
      total++; if (af !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_af n=%0d got=%b exp=%b", i + 1, af, i + 1 >= 14); end
      total++; if (full !== (i == 15)) begin bad++; $display("FAIL fill_full n=%0d got=%b exp=%b", i + 1, full, i == 15); end
    end
    din = 16'hDEAD;
    cyc();
    push = 1'b0;
    total++; if (cnt !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", cnt); end
    total++; if (dout !== 16'h0100) begin bad++; $display("FAIL ovf_head got=%h exp=0100", dout); end
    total++; if (ovf !== ERR) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", ovf, ERR); end
  endtask

  task automatic test_full_pushpop();
    logic [15:0] exp;
    push = 1'b1; pop = 1'b1; din = 16'hBEEF;
    cyc();
    push = 1'b0; pop = 1'b0;
    total++; if (cnt !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fpp_count got=%0d/%b exp=16/1", cnt, full); end
    total++; if (dout !== 16'h0101) begin bad++; $display("FAIL fpp_head got=%h exp=0101", dout); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 16'h0101 + 16'(i) : 16'hBEEF;
      total++; if (dout !== exp) begin bad++; $display("FAIL drain i=%0d got=%h exp=%h", i, dout, exp); end
      pop = 1'b1; cyc(); pop = 1'b0;
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_pushpop();
    push = 1'b1; pop = 1'b1; din = 16'h0555;
    cyc();
    push = 1'b0; pop = 1'b0;
    total++; if (cnt !== 5'd1) begin bad++; $display("FAIL epp_count got=%0d exp=1", cnt); end
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL epp_unf got=%b exp=0", unf); end
    total++; if (dout !== 16'h0555) begin bad++; $display("FAIL epp_dout got=%h exp=0555", dout); end
    pop = 1'b1; cyc(); cyc(); pop = 1'b0;
    total++; if (cnt !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL udf_state got=%0d/%b exp=0/1", cnt, empty); end
    total++; if (unf !== ERR) begin bad++; $display("FAIL udf_flag got=%b exp=%b", unf, ERR); end
  endtask

  task automatic test_clear();
    logic       so, su;
    logic [15:0] w;
    push = 1'b1;
    for (int i = 0; i < 7; i++) begin din = 16'($urandom); cyc(); end
    total++; if (cnt !== 5'd7) begin bad++; $display("FAIL clr_pre got=%0d exp=7", cnt); end
    so = m_ovf; su = m_unf;
    clr = 1'b1; din = 16'h0777;
    cyc();
    clr = 1'b0; push = 1'b0;
    total++; if (cnt !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL clr_state got=%0d/%b exp=0/1", cnt, empty); end
    total++; if (dout !== 16'h0) begin bad++; $display("FAIL clr_dout got=%h exp=0000", dout); end
    total++; if ({ovf, unf} !== {so, su}) begin bad++; $display("FAIL clr_flags got=%b%b exp=%b%b", ovf, unf, so, su); end
    w = 16'($urandom); push = 1'b1; din = w; cyc(); push = 1'b0;
    total++; if (dout !== w || cnt !== 5'd1) begin bad++; $display("FAIL clr_after got=%h/%0d exp=%h/1", dout, cnt, w); end
  endtask

  task automatic test_reset_mid();
    push = 1'b1;
    for (int i = 0; i < 6; i++) begin din = 16'($urandom); cyc(); end
    push = 1'b0;
    total++; if (cnt !== 5'd7) begin bad++; $display("FAIL rmid_pre got=%0d exp=7", cnt); end
    rst = 1'b1; cyc(); rst = 1'b0;
    total++; if ({cnt, empty, full, af, dout, ovf, unf} !== {5'd0, 1'b1, 1'b0, 1'b0, 16'h0, 2'b00}) begin
      bad++; $display("FAIL rmid_state got=%0d/%b/%b/%b/%h/%b%b exp=0/1/0/0/0000/00", cnt, empty, full, af, dout, ovf, unf);
    end
  endtask

  // Incrementing pattern through the 5-deep FIFO: the head is always the oldest value
  task automatic test_wrap();
    logic [15:0] nxt, head;
    bool_guard: begin end
    nxt = 16'h1000; head = 16'h1000;
    push5 = 1'b1;
    for (int i = 0; i < 4; i++) begin din5 = nxt; nxt++; cyc(); end
    pop5 = 1'b1;
    for (int i = 0; i < 23; i++) begin
      total++; if (dout5 !== head) begin bad++; $display("FAIL wrap_head i=%0d got=%h exp=%h", i, dout5, head); end
      din5 = nxt; nxt++; head++;
      cyc();
      total++; if (cnt5 !== 3'd4) begin bad++; $display("FAIL wrap_count i=%0d got=%0d exp=4", i, cnt5); end
    end
    push5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (dout5 !== head) begin bad++; $display("FAIL wrap_drain got=%h exp=%h", dout5, head); end
      head++; cyc();
    end
    pop5 = 1'b0;
    total++; if (empty5 !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty5); end
  endtask

  task automatic test_random();
    logic [26:0] got, exp;
    logic [24:0] got5, exp5;
    int s;
    for (int n = 0; n < 400; n++) begin
      push = ($urandom_range(0, 3) != 0); pop = ($urandom_range(0, 2) == 0);
      if (n >= 200) pop = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 59) == 0); din = 16'($urandom);
      push5 = $urandom_range(0, 1) == 1; pop5 = $urandom_range(0, 1) == 1;
      clr5 = ($urandom_range(0, 59) == 0); din5 = 16'($urandom);
      cyc();
      s = q16.size();
      exp = {5'(s), s == 0, s == 16, (16 - s) <= 2, (s > 0) ? q16[0] : 16'h0, m_ovf, m_unf};
      got = {cnt, empty, full, af, dout, ovf, unf};
      total++; if (got !== exp) begin bad++; $display("FAIL rand16 n=%0d got=%h exp=%h", n, got, exp); end
      s = q5.size();
      exp5 = {3'(s), s == 0, s == 5, (5 - s) <= 2, (s > 0) ? q5[0] : 16'h0, m_ovf5, m_unf5};
      got5 = {cnt5, empty5, full5, af5, dout5, ovf5, unf5};
      total++; if (got5 !== exp5) begin bad++; $display("FAIL rand5 n=%0d got=%h exp=%h", n, got5, exp5); end
    end
    push = 1'b0; pop = 1'b0; clr = 1'b0; push5 = 1'b0; pop5 = 1'b0; clr5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_pushpop();
    test_empty_pushpop();
    test_clear();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_fifo.md
# psum_fifo

First-word-fall-through partial-sum FIFO that links neighbouring processing elements in a PE column. It sits downstream of one PE's `opsum_pixel`/`push_opsum` port and upstream of the next PE's `ipsum_pixel`/`pop_ipsum` port. The PE samples `ipsum_pixel` in the same cycle it asserts `pop_ipsum`, so the head word is always presented combinationally. Full/empty status feeds back to the producing PE's `opsum_fifo_full` and the consuming PE's `ipsum_fifo_empty`.

## Interface
Parameters:
- `DATA_WIDTH`, 16, psum word width
- `DEPTH`, 16, number of entries; any integer ≥ 2
- `AF_MARGIN`, 2, `almost_full` asserts when free slots ≤ `AF_MARGIN`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `clear`  in  1  synchronous flush (pointers/count to zero, memory untouched)
- `push`  in  1  write request (from producer `push_opsum`)
- `din`  in  DATA_WIDTH  write data (from producer `opsum_pixel`)
- `full`  out  1  count == DEPTH
- `almost_full`  out  1  (DEPTH − count) ≤ AF_MARGIN
- `pop`  in  1  read request (from consumer `pop_ipsum`)
- `dout`  out  DATA_WIDTH  head word; 0 when empty
- `empty`  out  1  count == 0
- `count`  out  $clog2(DEPTH+1)  current occupancy
- `overflow`  out  1  sticky error (only with `PSUM_FIFO_ERR_EN`)
- `underflow`  out  1  sticky error (only with `PSUM_FIFO_ERR_EN`)

## Operation
- Storage: DEPTH × DATA_WIDTH register array, write pointer `wp`, read pointer `rp`, occupancy counter `count`; pointers wrap from DEPTH−1 to 0 (no power-of-two requirement).
- Push accepted when `push & (~full | pop)`: mem[wp] ← din, wp advances.
- Pop accepted when `pop & ~empty`: rp advances.
- count: +1 on accepted push only, −1 on accepted pop only, unchanged when both or neither.
- Simultaneous push+pop while full: both accepted, count stays DEPTH, full stays 1.
- Simultaneous push+pop while empty: pop ignored, push accepted, count → 1. No bypass: din is not visible on dout in the same cycle.
- Push while full without pop: dropped, memory and wp unchanged.
- Pop while empty: ignored, no state change.
- `dout` = mem[rp] when ~empty, else all zeros (combinational, no register stage).
- Priority: reset > clear > push/pop.
- `clear`: wp, rp, count ← 0; push/pop in the same cycle ignored; error flags are not cleared.

## Timing
- Reset values: empty=1, full=0, almost_full=(DEPTH ≤ AF_MARGIN), count=0, dout=0, overflow=0, underflow=0.
- Write-to-read latency: 1 cycle (word pushed at edge N is on dout and empty=0 after edge N).
- Pop-to-next-head: next word on dout after the popping edge.
- full, empty, almost_full and count are derived from registered count only; they have no combinational path from push/pop.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-stream: contents are abandoned; the FIFO is empty the cycle after reset.

## Configuration
- `PSUM_FIFO_ERR_EN` defined: `overflow` sets on `push & full & ~pop` and `underflow` sets on `pop & empty`. Both are sticky until `reset` (not `clear`).
- Not defined: `overflow` and `underflow` are tied to 0 and no error-detect logic is built.

## Test plan
- Reset, then push 0x0011, 0x0022, 0x0033 on consecutive cycles -> count 1,2,3. dout shows 0x0011 one cycle after the first push. Three pops return 0x0011, 0x0022, 0x0033, then empty=1 and dout=0.
- DEPTH=16: push 16 words 0x0100..0x010F -> almost_full at count 14, full at 16. The 17th push (0xDEAD) is dropped and, with ERR_EN, overflow=1. Draining yields 0x0100..0x010F in order.
- Full FIFO, push 0xBEEF with pop in the same cycle -> count stays 16, head advances. 0xBEEF emerges as the 16th word after draining.
- Empty FIFO, push 0x0555 with pop in the same cycle -> count=1, underflow stays 0, dout=0x0555 next cycle.
- Pointer wrap: DEPTH=5, 23 push/pop pairs of an incrementing pattern -> FIFO order is preserved across wraps and count never exceeds 5.
- Mid-stream `clear` with count=7, asserted together with push 0x0777 -> count=0, empty=1, the push is ignored, and sticky flags are unchanged. Separately, `reset` with count=7 -> all outputs at their reset values next cycle.
